// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: IDLE/ACCESS/RESP FSM, one transaction per two cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0 wins).
module data_mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          sel;
    logic          win;
    logic          arb;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] resp_data;

`ifdef DMEM_ARB_RR_EN
    logic ptr;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = ptr;
        end
    end
`else
    always_comb begin
        win = !req0;
    end
`endif

    // Arbitration edges are the ends of IDLE and RESP only.
    assign arb = (state != ACCESS) && (req0 || req1);

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = arb ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = arb ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sel   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            ptr   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (arb) begin
                sel <= win;
`ifdef DMEM_ARB_RR_EN
                ptr <= !win;
`endif
            end
        end
    end

    // Request payload is latched without reset; it is only observed in ACCESS/RESP.
    always_ff @(posedge CLK) begin
        if (arb) begin
            lat_we    <= win ? we1    : we0;
            lat_addr  <= win ? addr1  : addr0;
            lat_wdata <= win ? wdata1 : wdata0;
        end
    end

    assign resp_data = lat_we ? '0 : mem_rdata;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ACCESS) begin
            gnt0      = !sel;
            gnt1      = sel;
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
        end else if (state == RESP) begin
            rvalid0 = !sel;
            rvalid1 = sel;
            if (sel) begin
                rdata1 = resp_data;
            end else begin
                rdata0 = resp_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: per-port expected-response queues, small memory model.
// Contention expectations follow DMEM_ARB_RR_EN when defined.
module tb_data_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory: one-cycle read latency, writes land on the ACCESS-ending edge.
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // Response monitor and per-cycle invariants.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("gnt_excl", 64'(gnt0 & gnt1), 0);
            chk("rvalid_excl", 64'(rvalid0 & rvalid1), 0);
            if (!mem_en) chk("mem_idle_zero", 64'(|{mem_we, mem_addr, mem_wdata}), 0);
            if (rvalid0) begin
                if (q0.size() == 0) chk("rv0_unexpected", 64'(rvalid0), 0);
                else chk("rdata0", rdata0, q0.pop_front());
            end else begin
                chk("rdata0_zero", rdata0, 0);
            end
            if (rvalid1) begin
                if (q1.size() == 0) chk("rv1_unexpected", 64'(rvalid1), 0);
                else chk("rdata1", rdata1, q1.pop_front());
            end else begin
                chk("rdata1_zero", rdata1, 0);
            end
        end
    end

    task automatic push_exp(input int port, input logic we, input logic [63:0] addr,
                            input logic [63:0] wd);
        logic [63:0] e;
        e = we ? 64'h0 : shadow[addr[7:0]];
        if (we) shadow[addr[7:0]] = wd;
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic drive(input int port, input logic r, input logic we,
                         input logic [63:0] addr, input logic [63:0] wd);
        if (port == 0) begin
            req0 = r; we0 = we; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = r; we1 = we; addr1 = addr; wdata1 = wd;
        end
    endtask

    task automatic xact(input int port, input logic we, input logic [63:0] addr,
                        input logic [63:0] wd);
        bit got;
        @(posedge CLK) #1;
        push_exp(port, we, addr, wd);
        drive(port, 1'b1, we, addr, wd);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge CLK);
            if ((port == 0) ? gnt0 : gnt1) got = 1;
        end
        chk("gnt_seen", 64'(got), 1);
        if (got) begin
            chk("acc_mem_en", 64'(mem_en), 1);
            chk("acc_mem_we", 64'(mem_we), 64'(we));
            chk("acc_mem_addr", mem_addr, addr);
            if (we) chk("acc_mem_wdata", mem_wdata, wd);
        end
        @(posedge CLK) #1;
        drive(port, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 64'(|{gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                       mem_en, mem_we, mem_addr, mem_wdata}), 0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK) #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101;
            shadow[i] = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101;
        end
        mem[8'h10]    = 64'hDEAD_BEEF;
        shadow[8'h10] = 64'hDEAD_BEEF;
        mem_rdata = '0;
        RST = 1'b1;
        drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset_outputs");
        @(posedge CLK) #1 RST = 1'b0;

        // Single read on port 0, cycle-exact.
        @(posedge CLK) #1;
        push_exp(0, 1'b0, 64'h10, 64'h0);
        drive(0, 1'b1, 1'b0, 64'h10, 64'h0);
        @(negedge CLK);
        chk("rd_idle_gnt0", 64'(gnt0), 0);
        @(negedge CLK);
        chk("rd_gnt0", 64'(gnt0), 1);
        chk("rd_mem_en", 64'(mem_en), 1);
        chk("rd_mem_addr", mem_addr, 64'h10);
        chk("rd_mem_we", 64'(mem_we), 0);
        @(posedge CLK) #1;
        drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
        @(negedge CLK);
        chk("rd_rvalid0", 64'(rvalid0), 1);

        // Single write on port 1, then read it back from port 0.
        xact(1, 1'b1, 64'h8, 64'h55);
        xact(0, 1'b0, 64'h8, 64'h0);
        xact(1, 1'b0, 64'h33, 64'h0);
        xact(0, 1'b1, 64'h40, 64'hCAFE_F00D_1234_5678);
        xact(1, 1'b0, 64'h40, 64'h0);

        // Contention from a fresh reset: both ports hold reads for four grants.
        pulse_reset();
        @(posedge CLK) #1;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            push_exp(k % 2, 1'b0, (k % 2 == 0) ? 64'h20 : 64'h21, 64'h0);
`else
            push_exp(0, 1'b0, 64'h20, 64'h0);
`endif
        end
        drive(0, 1'b1, 1'b0, 64'h20, 64'h0);
        drive(1, 1'b1, 1'b0, 64'h21, 64'h0);
        @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            int exp_port;
            @(negedge CLK);
`ifdef DMEM_ARB_RR_EN
            exp_port = (k / 2) % 2;
`else
            exp_port = 0;
`endif
            if (k % 2 == 0) begin
                chk("cont_gnt0", 64'(gnt0), 64'(exp_port == 0));
                chk("cont_gnt1", 64'(gnt1), 64'(exp_port == 1));
            end else begin
                chk("cont_resp_nognt", 64'(gnt0 | gnt1), 0);
            end
        end
        drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (3) @(negedge CLK);
        chk("cont_q0_drained", 64'(q0.size()), 0);
        chk("cont_q1_drained", 64'(q1.size()), 0);

        // Reset during ACCESS of a port-0 read: aborted, then re-granted.
        @(posedge CLK) #1;
        drive(0, 1'b1, 1'b0, 64'h30, 64'h0);
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_acc_gnt0", 64'(gnt0), 1);
        RST = 1'b1;
        @(posedge CLK) #1;
        RST = 1'b0;
        push_exp(0, 1'b0, 64'h30, 64'h0);
        @(negedge CLK);
        check_all_zero("rst_abort_zero");
        begin
            bit got = 0;
            for (int i = 0; i < 6 && !got; i++) begin
                @(negedge CLK);
                if (gnt0) got = 1;
            end
            chk("rst_regrant0", 64'(got), 1);
        end
        @(posedge CLK) #1;
        drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (2) @(negedge CLK);
        chk("rst_q0_drained", 64'(q0.size()), 0);

        // Back-to-back: port 0 issues a new request in its RESP cycle.
        @(posedge CLK) #1;
        push_exp(0, 1'b0, 64'h11, 64'h0);
        drive(0, 1'b1, 1'b0, 64'h11, 64'h0);
        @(negedge CLK);
        @(negedge CLK);
        chk("b2b_gnt_a", 64'(gnt0), 1);
        @(posedge CLK) #1;
        push_exp(0, 1'b0, 64'h12, 64'h0);
        drive(0, 1'b1, 1'b0, 64'h12, 64'h0);
        @(negedge CLK);
        chk("b2b_resp_rvalid", 64'(rvalid0), 1);
        @(negedge CLK);
        chk("b2b_gnt_b", 64'(gnt0), 1);
        chk("b2b_mem_en", 64'(mem_en), 1);
        chk("b2b_mem_addr", mem_addr, 64'h12);
        @(posedge CLK) #1;
        drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (3) @(negedge CLK);
        check_all_zero("final_idle");
        chk("final_q0_drained", 64'(q0.size()), 0);
        chk("final_q1_drained", 64'(q1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
